// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   state_t       : request FSM states (RUN / WAIT / DROP)
//   fetch_entry_t : one buffered fetch, instruction plus its PC+4
package fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [PC_W-1:0]    PC_STEP       = 32'd4;
  localparam logic [PC_W-1:0]    PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory req/gnt/rvalid handshake,
// IF/ID head presentation with ID-side ready, and branch redirect.
//   master : the fetch queue (drives imem request and ID head)
//   slave  : the environment (memory, decoder, branch resolution)
interface fetch_queue_if;
  import fetch_pkg::*;

  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               id_valid_o;
  logic [INSTR_W-1:0] id_instr_o;
  logic [PC_W-1:0]    id_pc4_o;
  logic               id_ready_i;
  logic               redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output id_valid_o, id_instr_o, id_pc4_o,
    input  id_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  id_valid_o, id_instr_o, id_pc4_o,
    output id_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched instructions.
//   clk_i, rst_n : clock, async active-low reset
//   push / wdata : write one entry at the tail
//   pop          : drop the head (ignored when empty)
//   flush        : empty the buffer and reset pointers (wins over push/pop)
//   head, count  : current head entry and occupancy 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the PC, issues one word fetch at a
// time, buffers responses with PC+4 for the IF/ID register, and handles
// ID stalls and branch redirects.
//   clk_i, rst_n : clock, async active-low reset
//   bus          : fetch_queue_if.master (imem handshake, ID head, redirect)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           rst_n,
  fetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic             req;
  logic             push;
  logic             pop;
  logic             valid;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     wdata;

  // A request is only issued with a free slot, which stays reserved
  // because occupancy can only fall while the response is pending.
  assign req   = rst_n && (state_q == RUN) && (count < CNT_W'(DEPTH)) && !bus.redirect_i;
  assign push  = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
  assign pop   = valid && bus.id_ready_i && !bus.redirect_i;
  assign valid = (count != '0);
  assign wdata = '{instr: bus.imem_rdata_i, pc4: pc_q + PC_STEP};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  // Next state and PC; a redirect overrides any PC advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;

    if (bus.redirect_i) pc_d = bus.redirect_pc_i & PC_ALIGN_MASK;
    else if (push)      pc_d = pc_q + PC_STEP;

    case (state_q)
      RUN:  if (req && bus.imem_gnt_i) state_d = WAIT;
      // A same-cycle rvalid retires the pending fetch even under redirect.
      WAIT: begin
        if (bus.imem_rvalid_i)   state_d = RUN;
        else if (bus.redirect_i) state_d = DROP;
      end
      DROP: if (bus.imem_rvalid_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.id_valid_o  = valid;
  assign bus.id_instr_o  = valid ? head.instr : NOP_INSTR;
  assign bus.id_pc4_o    = valid ? head.pc4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a queue-based reference model and
// a responsive instruction-memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned     DEPTH    = 4;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [31:0]  m_pc;
  bit           m_out;
  bit           m_drop;
  fetch_entry_t m_q[$];
  logic [31:0]  pop_log[$];

  // memory model state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_lat;

  // stimulus knobs
  int          gnt_pct, ready_pct, redir_pct, lat_min, lat_max;
  bit          redir_now;
  logic [31:0] redir_tgt;

  // values driven / sampled this cycle
  bit          d_gnt, d_ready, d_redir, d_rvalid;
  logic [31:0] d_tgt, d_rdata;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit m_req();
    return !m_out && (m_q.size() < DEPTH) && !d_redir;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_out    = 0;
    m_drop   = 0;
    m_q.delete();
    pop_log.delete();
    mem_pend = 0;
    mem_lat  = 0;
  endtask

  task automatic drive_idle();
    d_gnt = 0; d_ready = 0; d_redir = 0; d_rvalid = 0;
    d_tgt = '0; d_rdata = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
  endtask

  // One clock cycle: drive at negedge, compare, then advance the models.
  task automatic step();
    fetch_entry_t e;
    bit           req_m;
    @(negedge clk);
    d_gnt    = ($urandom_range(99) < gnt_pct);
    d_ready  = ($urandom_range(99) < ready_pct);
    d_redir  = redir_now || ($urandom_range(99) < redir_pct);
    d_tgt    = redir_now ? redir_tgt : $urandom();
    d_rvalid = mem_pend && (mem_lat == 0);
    if (mem_pend && mem_lat > 0) mem_lat--;
    d_rdata  = d_rvalid ? instr_of(mem_addr) : $urandom();
    bus.imem_gnt_i    = d_gnt;
    bus.imem_rvalid_i = d_rvalid;
    bus.imem_rdata_i  = d_rdata;
    bus.id_ready_i    = d_ready;
    bus.redirect_i    = d_redir;
    bus.redirect_pc_i = d_tgt;
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.id_valid_o;
    s_instr = bus.id_instr_o;
    s_pc4   = bus.id_pc4_o;
    req_m   = m_req();
    chk("req", 32'(s_req), 32'(req_m));
    if (req_m) chk("addr", s_addr, m_pc);
    if (m_q.size() > 0) begin
      chk("valid", 32'(s_valid), 32'd1);
      chk("instr", s_instr, m_q[0].instr);
      chk("pc4", s_pc4, m_q[0].pc4);
    end else begin
      chk("valid", 32'(s_valid), 32'd0);
      chk("instr_nop", s_instr, 32'h0);
      chk("pc4_zero", s_pc4, 32'h0);
    end
    @(posedge clk);
    if (d_rvalid) mem_pend = 0;
    if (s_req && d_gnt) begin
      mem_pend = 1;
      mem_addr = s_addr;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    if (m_q.size() > 0 && d_ready && !d_redir) begin
      e = m_q.pop_front();
      pop_log.push_back(e.pc4);
    end
    if (d_redir) begin
      m_q.delete();
      m_pc = d_tgt & 32'hFFFF_FFFC;
      if (m_out) begin
        if (d_rvalid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else if (m_out && d_rvalid) begin
      if (!m_drop) begin
        m_q.push_back('{instr: instr_of(m_pc), pc4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
      m_out  = 0;
      m_drop = 0;
    end else if (req_m && d_gnt) begin
      m_out = 1;
    end
    redir_now = 0;
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_instr", bus.id_instr_o, 32'h0);
    chk("rst_pc4", bus.id_pc4_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
    gnt_pct = g; ready_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    redir_now = 0;
    redir_tgt = '0;
    drive_idle();
    set_knobs(100, 100, 0, 0, 0);
    do_reset();

    // streaming with a one-cycle memory
    step();
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, RESET_PC);
    repeat (19) step();
    chk("throughput", 32'(pop_log.size()), 32'd9);
    chk("stream_pc4_0", pop_log[0], 32'd4);
    chk("stream_pc4_1", pop_log[1], 32'd8);
    chk("stream_pc4_2", pop_log[2], 32'd12);

    // stall until full, then drain
    do_reset();
    set_knobs(100, 0, 0, 0, 0);
    repeat (10) step();
    chk("full_req", 32'(s_req), 32'd0);
    chk("full_head_pc4", s_pc4, 32'd4);
    set_knobs(100, 100, 0, 0, 0);
    repeat (2) step();
    chk("resume_req", 32'(s_req), 32'd1);
    chk("resume_addr", s_addr, 32'd16);
    repeat (2) step();
    chk("drain_n", 32'(pop_log.size()), 32'd4);
    chk("drain_0", pop_log[0], 32'd4);
    chk("drain_1", pop_log[1], 32'd8);
    chk("drain_2", pop_log[2], 32'd12);
    chk("drain_3", pop_log[3], 32'd16);

    // redirect while a response is pending
    set_knobs(100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && !m_out; i++) step();
    chk("p3_outstanding", 32'(m_out), 32'd1);
    redir_now = 1; redir_tgt = 32'h100;
    step();
    step();
    chk("p3_flushed", 32'(s_valid), 32'd0);
    for (int i = 0; i < 20 && !s_req; i++) step();
    chk("p3_req", 32'(s_req), 32'd1);
    chk("p3_addr", s_addr, 32'h100);
    for (int i = 0; i < 30 && !s_valid; i++) step();
    chk("p3_head_pc4", s_pc4, 32'h104);
    chk("p3_head_instr", s_instr, instr_of(32'h100));

    // redirect coinciding with rvalid and pop, then grant starvation
    set_knobs(100, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !(m_out && m_q.size() > 0); i++) step();
    chk("p4_setup", 32'(m_out && m_q.size() > 0), 32'd1);
    set_knobs(0, 100, 0, 0, 0);
    redir_now = 1; redir_tgt = 32'h200;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p5_req_held", 32'(s_req), 32'd1);
      chk("p5_addr_held", s_addr, 32'h200);
      chk("p5_empty", 32'(s_valid), 32'd0);
    end
    redir_now = 1; redir_tgt = 32'h303;
    step();
    chk("p5_withdraw", 32'(s_req), 32'd0);
    step();
    chk("p5_rereq", 32'(s_req), 32'd1);
    chk("p5_readdr", s_addr, 32'h300);

    // reset while waiting for a response
    set_knobs(100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && !m_out; i++) step();
    chk("p6_outstanding", 32'(m_out), 32'd1);
    do_reset();
    step();
    chk("p6_restart_req", 32'(s_req), 32'd1);
    chk("p6_restart_addr", s_addr, RESET_PC);

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20),
                $urandom_range(5, 0), 0, $urandom_range(3, 0));
      repeat (200) step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
